pipe_fetch: RTL

- Fetch stage plus IF/ID pipeline register of the pipelined ARM core.
- Owns the PC and issues instruction-memory requests through a ready handshake. Applies branch and PC-write redirects.
- Delivers InstrD/PCPlus8D to decode. InstrD[23:0] feeds the decode-stage immediate extender.
- A one-entry skid buffer absorbs a fetch that completes while decode is stalled.

---
 rtl/pipe_fetch.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_fetch.sv
// Fetch stage and IF/ID pipeline register: PC ownership, ready-handshake instruction fetch,
// redirect handling and a one-entry skid buffer. Optional PIPE_FETCH_PERF_EN adds FetchWaitCnt.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [31:0]      ALUResultE,
    input  logic             PCSrcW,
    input  logic [31:0]      ResultW,
    output logic             ImemReq,
    output logic [31:0]      ImemAddr,
    input  logic             ImemRdy,
    input  logic [31:0]      ImemRData,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus8D,
    output logic             ValidD,
`ifdef PIPE_FETCH_PERF_EN
    output logic             FetchBusy,
    output logic [CNT_W-1:0] FetchWaitCnt
`else
    output logic             FetchBusy
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        redirect;
    logic [31:0] target;
    logic        hs;

    logic        pend_v;
    logic [31:0] pend_pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc8;

    logic        pc_ld_target;
    logic        pc_ld_pend;
    logic        pc_inc;
    logic        fetch_ok;
    logic        pend_wr;
    logic        pend_clr;
    logic        skid_drain;
    logic        load_word;
    logic        skid_wr;

    assign PCF      = pc;
    assign ImemAddr = pc;
    assign pc_plus8 = pc + 32'd8;

    // Execute-stage branch outranks a writeback PC write when both fire together.
    always_comb begin
        redirect = BranchTakenE | PCSrcW;
        target   = BranchTakenE ? ALUResultE : ResultW;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    state_n = S_IDLE;
                end else if (hs) begin
                    state_n = (StallD && !FlushD) ? S_HOLD : S_IDLE;
                end else if (ImemReq) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hs) begin
                    if (pend_v || redirect) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = (StallD && !FlushD) ? S_HOLD : S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (redirect || FlushD || !StallD) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Request is forced low while reset is held so memory never sees a stale WAIT request.
    always_comb begin
        ImemReq      = 1'b0;
        pc_ld_target = 1'b0;
        pc_ld_pend   = 1'b0;
        pc_inc       = 1'b0;
        fetch_ok     = 1'b0;
        pend_wr      = 1'b0;
        pend_clr     = 1'b0;
        skid_drain   = 1'b0;
        case (state)
            S_IDLE:  ImemReq = !StallF;
            S_WAIT:  ImemReq = 1'b1;
            default: ImemReq = 1'b0;
        endcase
        if (!reset) begin
            ImemReq = 1'b0;
        end
        hs        = ImemReq & ImemRdy;
        FetchBusy = ImemReq & !ImemRdy;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_ld_target = 1'b1;
                end else if (hs) begin
                    pc_inc   = 1'b1;
                    fetch_ok = 1'b1;
                end
            end
            S_WAIT: begin
                if (hs) begin
                    pend_clr = 1'b1;
                    if (redirect) begin
                        pc_ld_target = 1'b1;
                    end else if (pend_v) begin
                        pc_ld_pend = 1'b1;
                    end else begin
                        pc_inc   = 1'b1;
                        fetch_ok = 1'b1;
                    end
                end else if (redirect) begin
                    pend_wr = 1'b1;
                end
            end
            S_HOLD: begin
                pc_ld_target = redirect;
                skid_drain   = !redirect && !FlushD && !StallD;
            end
            default: ;
        endcase
        load_word = fetch_ok && !StallD && !FlushD;
        skid_wr   = fetch_ok && StallD && !FlushD;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (pc_ld_target) begin
            pc <= target;
        end else if (pc_ld_pend) begin
            pc <= pend_pc;
        end else if (pc_inc) begin
            pc <= pc + 32'd4;
        end
    end

    // A redirect seen while a fetch is in flight waits here until that fetch retires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_v  <= 1'b0;
            pend_pc <= 32'd0;
        end else if (pend_clr) begin
            pend_v <= 1'b0;
        end else if (pend_wr) begin
            pend_v  <= 1'b1;
            pend_pc <= target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            skid_instr <= 32'd0;
            skid_pc8   <= 32'd0;
        end else if (skid_wr) begin
            skid_instr <= ImemRData;
            skid_pc8   <= pc_plus8;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            InstrD   <= 32'd0;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= 32'd0;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (load_word) begin
                InstrD   <= ImemRData;
                PCPlus8D <= pc_plus8;
                ValidD   <= 1'b1;
            end else if (skid_drain) begin
                InstrD   <= skid_instr;
                PCPlus8D <= skid_pc8;
                ValidD   <= 1'b1;
            end else begin
                ValidD <= 1'b0;
            end
        end
    end

`ifdef PIPE_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            FetchWaitCnt <= '0;
        end else if (FetchBusy && (FetchWaitCnt != '1)) begin
            FetchWaitCnt <= FetchWaitCnt + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
